// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
// Buffers CPU traffic to and from a UART core. CPU writes fill a TX FIFO.
// A feeder FSM hands TX bytes to the UART one at a time using the
// start-request / busy handshake. An RX FIFO captures one byte per rising
// edge of the UART receive flag.
// Ports:
//   i_clk, i_rst         clock, synchronous active-low reset
//   i_en                 UART enable; gates the feeder and RX capture
//   i_wr_tx, i_wdata     CPU push into TX FIFO
//   o_tx_full, o_tx_count  TX FIFO status
//   i_rd_rx, o_rdata     CPU pop from RX FIFO (first-word fall-through head)
//   o_rx_empty, o_rx_count RX FIFO status
//   o_rx_overrun, i_clr_ovr  sticky drop flag and its clear
//   o_str_tx, o_data_tx, i_busy_tx  transmit handshake to UART core
//   i_rxne, i_data_rx    UART received-byte flag and data
module uart_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_wr_tx,
    input  logic [7:0]            i_wdata,
    output logic                  o_tx_full,
    output logic [DEPTH_LOG2:0]   o_tx_count,
    input  logic                  i_rd_rx,
    output logic [7:0]            o_rdata,
    output logic                  o_rx_empty,
    output logic [DEPTH_LOG2:0]   o_rx_count,
    output logic                  o_rx_overrun,
    input  logic                  i_clr_ovr,
    output logic                  o_str_tx,
    output logic [7:0]            o_data_tx,
    input  logic                  i_busy_tx,
    input  logic                  i_rxne,
    input  logic [7:0]            i_data_rx
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } feed_state_e;

    feed_state_e             state_q, state_d;
    logic                    str_tx_q, str_tx_d;
    logic [7:0]              data_tx_q, data_tx_d;

    logic [7:0]              tx_mem_q [DEPTH];
    logic [7:0]              tx_mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2:0]     tx_count_q, tx_count_d;

    logic [7:0]              rx_mem_q [DEPTH];
    logic [7:0]              rx_mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [DEPTH_LOG2:0]     rx_count_q, rx_count_d;

    logic                    rxne_q, rxne_d;
    logic                    ovr_q, ovr_d;

    logic                    tx_empty_s, tx_full_s, tx_push_s, tx_pop_s;
    logic                    rx_empty_s, rx_full_s, rx_push_s, rx_pop_s;
    logic                    rx_rise_s, ovr_set_s;

    assign tx_empty_s = (tx_count_q == CNT_ZERO);
    assign tx_full_s  = (tx_count_q == CNT_FULL);
    assign rx_empty_s = (rx_count_q == CNT_ZERO);
    assign rx_full_s  = (rx_count_q == CNT_FULL);

    // Feeder FSM next state; the head is only popped once the UART shows busy,
    // so a byte interrupted by i_en=0 stays queued for retransmission.
    always_comb begin
        state_d   = state_q;
        str_tx_d  = str_tx_q;
        data_tx_d = data_tx_q;
        tx_pop_s  = 1'b0;
        if (!i_en) begin
            state_d  = F_IDLE;
            str_tx_d = 1'b0;
        end else begin
            case (state_q)
                F_IDLE: begin
                    str_tx_d = 1'b0;
                    if (!tx_empty_s && !i_busy_tx) begin
                        data_tx_d = tx_mem_q[tx_rd_ptr_q];
                        str_tx_d  = 1'b1;
                        state_d   = F_REQ;
                    end else begin
                        state_d   = F_IDLE;
                    end
                end
                F_REQ: begin
                    if (i_busy_tx) begin
                        tx_pop_s = 1'b1;
                        str_tx_d = 1'b0;
                        state_d  = F_WAIT;
                    end else begin
                        str_tx_d = 1'b1;
                    end
                end
                F_WAIT: begin
                    // data_tx is held: the UART samples it at the end of the start bit
                    str_tx_d = 1'b0;
                    if (!i_busy_tx) begin
                        state_d = F_IDLE;
                    end else begin
                        state_d = F_WAIT;
                    end
                end
                default: begin
                    state_d  = F_IDLE;
                    str_tx_d = 1'b0;
                end
            endcase
        end
    end

    // TX FIFO next state; a push while full is accepted when the feeder pops
    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        tx_push_s   = i_wr_tx && (!tx_full_s || tx_pop_s);
        if (tx_push_s) begin
            tx_mem_d[tx_wr_ptr_q] = i_wdata;
            tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
        end else begin
            tx_wr_ptr_d           = tx_wr_ptr_q;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
    end

    // RX FIFO next state; one push per rising edge of i_rxne, overrun on drop
    always_comb begin
        rxne_d      = i_rxne;
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        rx_rise_s   = i_en && i_rxne && !rxne_q;
        rx_pop_s    = i_rd_rx && !rx_empty_s;
        rx_push_s   = rx_rise_s && (!rx_full_s || rx_pop_s);
        ovr_set_s   = rx_rise_s && rx_full_s && !rx_pop_s;
        if (rx_push_s) begin
            rx_mem_d[rx_wr_ptr_q] = i_data_rx;
            rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
        end else begin
            rx_wr_ptr_d           = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
        // a new overrun beats a simultaneous clear
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= F_IDLE;
            str_tx_q    <= 1'b0;
            data_tx_q   <= 8'h00;
            tx_mem_q    <= '{default: 8'h00};
            tx_wr_ptr_q <= {DEPTH_LOG2{1'b0}};
            tx_rd_ptr_q <= {DEPTH_LOG2{1'b0}};
            tx_count_q  <= CNT_ZERO;
            rx_mem_q    <= '{default: 8'h00};
            rx_wr_ptr_q <= {DEPTH_LOG2{1'b0}};
            rx_rd_ptr_q <= {DEPTH_LOG2{1'b0}};
            rx_count_q  <= CNT_ZERO;
            rxne_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            str_tx_q    <= str_tx_d;
            data_tx_q   <= data_tx_d;
            tx_mem_q    <= tx_mem_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_mem_q    <= rx_mem_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            rxne_q      <= rxne_d;
            ovr_q       <= ovr_d;
        end
    end

    assign o_tx_full    = tx_full_s;
    assign o_tx_count   = tx_count_q;
    assign o_rdata      = rx_mem_q[rx_rd_ptr_q];
    assign o_rx_empty   = rx_empty_s;
    assign o_rx_count   = rx_count_q;
    assign o_rx_overrun = ovr_q;
    assign o_str_tx     = str_tx_q;
    assign o_data_tx    = data_tx_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Testbench for uart_fifo_bridge: directed steps plus randomized RX/TX traffic,
// checked against queue-based reference behaviour and a simple UART model.
module tb_uart_fifo_bridge;

    localparam int BUSY_LEN = 100;

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_wr_tx, i_rd_rx, i_clr_ovr, i_rxne;
    logic [7:0] i_wdata, i_data_rx;
    logic       o_tx_full, o_rx_empty, o_rx_overrun, o_str_tx;
    logic [4:0] o_tx_count, o_rx_count;
    logic [7:0] o_rdata, o_data_tx;
    logic       busy_tx;

    // UART model state: when uart_auto=1 busy follows the model, else busy_force
    logic       uart_auto = 1'b0;
    logic       busy_force = 1'b0;
    logic       busy_model = 1'b0;
    logic       pend = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] sent [$];

    int checks = 0;
    int errors = 0;

    assign busy_tx = uart_auto ? busy_model : busy_force;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en),
        .i_wr_tx(i_wr_tx), .i_wdata(i_wdata),
        .o_tx_full(o_tx_full), .o_tx_count(o_tx_count),
        .i_rd_rx(i_rd_rx), .o_rdata(o_rdata),
        .o_rx_empty(o_rx_empty), .o_rx_count(o_rx_count),
        .o_rx_overrun(o_rx_overrun), .i_clr_ovr(i_clr_ovr),
        .o_str_tx(o_str_tx), .o_data_tx(o_data_tx), .i_busy_tx(busy_tx),
        .i_rxne(i_rxne), .i_data_rx(i_data_rx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: busy rises one cycle after a request is seen and
    // lasts BUSY_LEN cycles; the byte presented must stay stable meanwhile.
    always @(negedge clk) begin
        if (!uart_auto) begin
            busy_cnt   = 0;
            pend       = 1'b0;
            busy_model = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            check("tx_data_held", {24'd0, o_data_tx}, {24'd0, cur_byte});
            if (busy_cnt == BUSY_LEN - 1) check("str_drop", {31'd0, o_str_tx}, 32'd0);
            if (busy_cnt == 0) busy_model = 1'b0;
        end else if (pend) begin
            pend       = 1'b0;
            busy_model = 1'b1;
            busy_cnt   = BUSY_LEN;
            cur_byte   = o_data_tx;
            sent.push_back(o_data_tx);
        end else if (o_str_tx && !busy_model) begin
            pend = 1'b1;
        end
    end

    // All tasks start and end at a falling edge
    task automatic wr(input logic [7:0] d);
        i_wr_tx = 1'b1; i_wdata = d;
        @(negedge clk);
        i_wr_tx = 1'b0;
    endtask

    task automatic rd();
        i_rd_rx = 1'b1;
        @(negedge clk);
        i_rd_rx = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input int width);
        i_rxne = 1'b1; i_data_rx = d;
        repeat (width) @(negedge clk);
        i_rxne = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx_idle(input string tag, input int budget);
        int n = 0;
        while (!(o_tx_count == 5'd0 && !busy_tx && !o_str_tx && !pend) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, n < budget}, 32'd1);
    endtask

    task automatic check_sent(input string tag, input logic [7:0] exp [$]);
        check(tag, sent.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sent.size(); i++)
            check(tag, {24'd0, sent[i]}, {24'd0, exp[i]});
    endtask

    task automatic check_rx(input string tag, input logic [7:0] q [$], input logic ovr);
        check({tag, "_cnt"}, {27'd0, o_rx_count}, q.size());
        check({tag, "_empty"}, {31'd0, o_rx_empty}, {31'd0, q.size() == 0});
        check({tag, "_ovr"}, {31'd0, o_rx_overrun}, {31'd0, ovr});
        if (q.size() > 0) check({tag, "_rdata"}, {24'd0, o_rdata}, {24'd0, q[0]});
    endtask

    initial begin
        logic [7:0] exp_tx [$];
        logic [7:0] rq [$];
        logic       rovr;
        logic [7:0] b;

        i_rst = 1'b0; i_en = 1'b1; i_wr_tx = 1'b0; i_wdata = 8'h00;
        i_rd_rx = 1'b0; i_clr_ovr = 1'b0; i_rxne = 1'b0; i_data_rx = 8'h00;
        repeat (2) @(negedge clk);
        // reset state
        check("rst_tx_count", {27'd0, o_tx_count}, 32'd0);
        check("rst_tx_full", {31'd0, o_tx_full}, 32'd0);
        check("rst_rx_empty", {31'd0, o_rx_empty}, 32'd1);
        check("rst_rx_count", {27'd0, o_rx_count}, 32'd0);
        check("rst_ovr", {31'd0, o_rx_overrun}, 32'd0);
        check("rst_str", {31'd0, o_str_tx}, 32'd0);
        check("rst_data_tx", {24'd0, o_data_tx}, 32'd0);
        i_rst = 1'b1;
        @(negedge clk);

        // three back-to-back writes through the handshaking UART model
        uart_auto = 1'b1;
        sent.delete();
        wr(8'h55); wr(8'hA3); wr(8'h0F);
        check("tx3_count", {27'd0, o_tx_count}, 32'd3);
        wait_tx_idle("tx3_timeout", 2000);
        check("tx3_count_end", {27'd0, o_tx_count}, 32'd0);
        exp_tx = '{8'h55, 8'hA3, 8'h0F};
        check_sent("tx3_seq", exp_tx);

        // fill with busy held high: 17th write ignored
        uart_auto = 1'b0; busy_force = 1'b1;
        sent.delete(); exp_tx.delete();
        for (int i = 0; i < 17; i++) begin
            wr(i[7:0]);
            if (i < 16) exp_tx.push_back(i[7:0]);
            if (i == 15) check("full16", {31'd0, o_tx_full}, 32'd1);
        end
        check("full17_count", {27'd0, o_tx_count}, 32'd16);
        busy_force = 1'b0; uart_auto = 1'b1;
        wait_tx_idle("full_drain_timeout", 4000);
        check_sent("full_seq", exp_tx);

        // RX: 2-cycle-wide pulses capture once each
        rq.delete(); rovr = 1'b0;
        rx_pulse(8'h31, 2); rq.push_back(8'h31);
        rx_pulse(8'h30, 2); rq.push_back(8'h30);
        check_rx("rx2", rq, rovr);
        rd(); void'(rq.pop_front());
        check_rx("rx2_rd1", rq, rovr);
        rd(); void'(rq.pop_front());
        check_rx("rx2_rd2", rq, rovr);

        // RX overflow with random data, then clear and a push+pop while full
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            rx_pulse(b, $urandom_range(1, 3));
            if (rq.size() < 16) rq.push_back(b); else rovr = 1'b1;
            if (i == 15) check_rx("rx16", rq, rovr);
        end
        check_rx("rx17", rq, rovr);
        i_clr_ovr = 1'b1; @(negedge clk); i_clr_ovr = 1'b0; rovr = 1'b0;
        check_rx("rx_clr", rq, rovr);
        b = 8'($urandom);
        i_rxne = 1'b1; i_data_rx = b; i_rd_rx = 1'b1;
        @(negedge clk);
        i_rxne = 1'b0; i_rd_rx = 1'b0;
        @(negedge clk);
        void'(rq.pop_front()); rq.push_back(b);
        check_rx("rx_full_rdwr", rq, rovr);
        while (rq.size() > 0) begin
            rd(); void'(rq.pop_front());
            check_rx("rx_drain", rq, rovr);
        end

        // drop enable while a request is pending, then re-send
        uart_auto = 1'b0; busy_force = 1'b0;
        wr(8'h7E);
        @(negedge clk);
        check("en_req_str", {31'd0, o_str_tx}, 32'd1);
        check("en_req_data", {24'd0, o_data_tx}, 32'h7E);
        i_en = 1'b0;
        @(negedge clk);
        check("en_off_str", {31'd0, o_str_tx}, 32'd0);
        check("en_off_count", {27'd0, o_tx_count}, 32'd1);
        repeat (3) @(negedge clk);
        check("en_off_hold", {31'd0, o_str_tx}, 32'd0);
        i_en = 1'b1; sent.delete(); uart_auto = 1'b1;
        wait_tx_idle("en_resend_timeout", 1000);
        exp_tx = '{8'h7E};
        check_sent("en_resend", exp_tx);

        // randomized TX bursts with random gaps
        sent.delete(); exp_tx.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            wr(b); exp_tx.push_back(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_tx_idle("rand_tx_timeout", 3000);
        check_sent("rand_tx", exp_tx);

        // randomized RX pulses and reads
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                b = 8'($urandom);
                rx_pulse(b, $urandom_range(1, 3));
                if (rq.size() < 16) rq.push_back(b); else rovr = 1'b1;
            end else begin
                rd();
                if (rq.size() > 0) void'(rq.pop_front());
            end
            check_rx("rand_rx", rq, rovr);
        end

        // reset in the middle of a transfer with both FIFOs occupied
        wr(8'h11); wr(8'h22); wr(8'h33);
        for (int i = 0; i < 17; i++) rx_pulse(8'($urandom), 1);
        check("pre_rst_ovr", {31'd0, o_rx_overrun}, 32'd1);
        uart_auto = 1'b0; i_rst = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;
        check("mid_rst_tx_count", {27'd0, o_tx_count}, 32'd0);
        check("mid_rst_rx_count", {27'd0, o_rx_count}, 32'd0);
        check("mid_rst_str", {31'd0, o_str_tx}, 32'd0);
        check("mid_rst_ovr", {31'd0, o_rx_overrun}, 32'd0);
        check("mid_rst_rx_empty", {31'd0, o_rx_empty}, 32'd1);
        check("mid_rst_tx_full", {31'd0, o_tx_full}, 32'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
